// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: store funct3 encodings, strobe width and buffered entry layout.
package store_buffer_pkg;
  localparam int STRB_W = 4;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       data;
    logic [STRB_W-1:0] strb;
  } entry_t;
endpackage

// File: rtl/store_align.sv
// store_align: lane-aligns store data, builds byte strobes and flags misaligned/illegal stores.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       waddr_o,
  output logic [31:0]       wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              misalign_o
);
  logic is_sb, is_sh, is_sw;
  always_comb begin
    is_sb      = funct3_i == F3_SB;
    is_sh      = funct3_i == F3_SH;
    is_sw      = funct3_i == F3_SW;
    waddr_o    = {addr_i[31:2], 2'b00};
    wdata_o    = is_sb ? {4{data_i[7:0]}} : is_sh ? {2{data_i[15:0]}} : data_i;
    wstrb_o    = is_sb ? STRB_W'(4'b0001 << addr_i[1:0]) :
                 is_sh ? (addr_i[1] ? 4'b1100 : 4'b0011) :
                 is_sw ? 4'b1111 : 4'b0000;
    // Unknown funct3 is treated like a misaligned store: accepted and dropped.
    misalign_o = is_sh ? addr_i[0] : is_sw ? |addr_i[1:0] : !is_sb;
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of formatted stores draining to data memory.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              misalign,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("store_buffer: DEPTH must be a power of two >= 2");
  end

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;
  entry_t           buf_q [DEPTH];
  entry_t           new_entry, head_entry;
  logic             mis, accept, push, pop;

  store_align u_align (
    .funct3_i   (req_funct3),
    .addr_i     (req_addr),
    .data_i     (req_data),
    .waddr_o    (new_entry.addr),
    .wdata_o    (new_entry.data),
    .wstrb_o    (new_entry.strb),
    .misalign_o (mis)
  );

  always_comb begin
    empty      = count_q == '0;
    req_ready  = count_q != CNT_W'(DEPTH);
    mem_valid  = !empty;
    accept     = req_valid && req_ready;
    push       = accept && !mis;
    pop        = mem_valid && mem_ready;
    head_entry = buf_q[head_q];
    // Outputs are forced to zero when empty so reset reads back as all-zero.
    mem_addr   = empty ? '0 : head_entry.addr;
    mem_wdata  = empty ? '0 : head_entry.data;
    mem_wstrb  = empty ? '0 : head_entry.strb;
    misalign   = misalign_q;
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(push);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    misalign_d = accept && mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[tail_q] <= new_entry;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer (DEPTH=4).
module tb_store_buffer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_data = '0;
  logic        mem_valid, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        misalign, empty;
  int          total = 0, passed = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .misalign(misalign), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_funct3 = f; req_addr = a; req_data = d;
  endtask

  task automatic test_reset;
    #3;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
    total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got %b want 0", mem_valid); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign); else passed++;
    total++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) $display("FAIL reset_mem_bus got %h %h %h want 0", mem_addr, mem_wdata, mem_wstrb); else passed++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sb;
    logic [31:0] a [2] = '{32'h0000_1003, 32'h0000_1001};
    logic [31:0] d [2] = '{32'h0000_00A5, 32'hFFFF_FF3C};
    logic [3:0]  s [2] = '{4'b1000, 4'b0010};
    logic [31:0] w [2] = '{32'hA5A5_A5A5, 32'h3C3C_3C3C};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(3'b000, a[i], d[i]);
      total++; if (mem_valid !== 1'b0) $display("FAIL sb_latency[%0d] mem_valid got %b want 0", i, mem_valid); else passed++;
      @(negedge clk);
      req_valid = 1'b0;
      total++; if (mem_addr !== 32'h0000_1000) $display("FAIL sb_addr[%0d] got %h want 00001000", i, mem_addr); else passed++;
      total++; if (mem_wstrb !== s[i]) $display("FAIL sb_strb[%0d] got %b want %b", i, mem_wstrb, s[i]); else passed++;
      total++; if (mem_wdata !== w[i]) $display("FAIL sb_data[%0d] got %h want %h", i, mem_wdata, w[i]); else passed++;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      total++; if (empty !== 1'b1) $display("FAIL sb_drain[%0d] empty got %b want 1", i, empty); else passed++;
    end
  endtask

  task automatic test_sh;
    @(negedge clk);
    drive(3'b001, 32'h0000_2002, 32'h1234_BEEF);
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (mem_addr !== 32'h0000_2000) $display("FAIL sh_addr got %h want 00002000", mem_addr); else passed++;
    total++; if (mem_wstrb !== 4'b1100) $display("FAIL sh_strb got %b want 1100", mem_wstrb); else passed++;
    total++; if (mem_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_data got %h want beefbeef", mem_wdata); else passed++;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL sh_drain empty got %b want 1", empty); else passed++;
  endtask

  task automatic test_misalign(input string nm, input logic [2:0] f, input logic [31:0] a);
    @(negedge clk);
    drive(f, a, 32'hDEAD_BEEF);
    total++; if (req_ready !== 1'b1) $display("FAIL %s ready got %b want 1", nm, req_ready); else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (misalign !== 1'b1) $display("FAIL %s pulse got %b want 1", nm, misalign); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL %s enqueued empty got %b want 1", nm, empty); else passed++;
    @(negedge clk);
    total++; if (misalign !== 1'b0) $display("FAIL %s pulse_end got %b want 0", nm, misalign); else passed++;
    total++; if (mem_valid !== 1'b0) $display("FAIL %s mem_valid got %b want 0", nm, mem_valid); else passed++;
  endtask

  task automatic test_full;
    logic sent = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(3'b010, 32'h0000_4000 + 32'(4 * i), 32'h1111_0000 + 32'(i));
    end
    @(negedge clk);
    drive(3'b010, 32'h0000_4010, 32'h0000_0055);
    total++; if (req_ready !== 1'b0) $display("FAIL full_ready got %b want 0", req_ready); else passed++;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) $display("FAIL full_hold_ready got %b want 0", req_ready); else passed++;
    total++; if (mem_addr !== 32'h0000_4000 || mem_wdata !== 32'h1111_0000) $display("FAIL full_stable got %h/%h want 00004000/11110000", mem_addr, mem_wdata); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sent) req_valid = 1'b0;
      total++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_4000 + 32'(4 * i) ||
          mem_wdata !== (i == 4 ? 32'h0000_0055 : 32'h1111_0000 + 32'(i)) || mem_wstrb !== 4'b1111)
        $display("FAIL full_order[%0d] got %b %h %h %b", i, mem_valid, mem_addr, mem_wdata, mem_wstrb);
      else passed++;
      if (req_valid && req_ready) sent = 1'b1;
      mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = 1'b0;
    total++; if (sent !== 1'b1) $display("FAIL full_fifth_accept got %b want 1", sent); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL full_drain empty got %b want 1", empty); else passed++;
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(3'b010, 32'h0000_5000 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (mem_valid !== 1'b1 || req_ready !== 1'b1 || mem_addr !== 32'h0000_5000 + 32'(4 * k) ||
          mem_wdata !== 32'hC0DE_0000 + 32'(k))
        $display("FAIL b2b[%0d] got v=%b r=%b %h %h", k, mem_valid, req_ready, mem_addr, mem_wdata);
      else passed++;
      drive(3'b010, 32'h0000_5000 + 32'(4 * (k + 2)), 32'hC0DE_0000 + 32'(k + 2));
      mem_ready = 1'b1;
    end
    for (int k = 10; k < 12; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (mem_addr !== 32'h0000_5000 + 32'(4 * k) || mem_wdata !== 32'hC0DE_0000 + 32'(k))
        $display("FAIL b2b_tail[%0d] got %h %h", k, mem_addr, mem_wdata);
      else passed++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL b2b_empty got %b want 1", empty); else passed++;
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(3'b010, 32'h0000_6000 + 32'(4 * k), 32'h7777_0000 + 32'(k));
    end
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (mem_valid !== 1'b1) $display("FAIL rmid_pre mem_valid got %b want 1", mem_valid); else passed++;
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    total++; if (mem_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", mem_valid); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL rmid_empty got %b want 1", empty); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", req_ready); else passed++;
    total++; if (mem_wstrb !== 4'b0000 || mem_addr !== 32'h0) $display("FAIL rmid_bus got %h %b want 0", mem_addr, mem_wstrb); else passed++;
    @(negedge clk);
    total++; if (mem_valid !== 1'b0) $display("FAIL rmid_hold got %b want 0", mem_valid); else passed++;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if (empty !== 1'b1 || mem_valid !== 1'b0) $display("FAIL rmid_discard got e=%b v=%b want 1/0", empty, mem_valid); else passed++;
  endtask

  initial begin
    test_reset;
    test_sb;
    test_sh;
    test_misalign("sh_misalign", 3'b001, 32'h0000_2001);
    test_misalign("sw_misalign", 3'b010, 32'h0000_3002);
    test_misalign("bad_funct3", 3'b011, 32'h0000_0000);
    test_full;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
